// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and slot helpers for the LEGv8 hazard/forwarding unit.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } hz_slot_t;
  localparam int SLOT_W = $bits(hz_slot_t);
  function automatic logic writes(hz_slot_t s, logic [REG_W-1:0] r);
    return s.valid && s.regwrite && s.rd == r && r != ZERO_REG;
  endfunction
  // A load still in EX cannot forward; that case is covered by the load-use stall.
  function automatic logic [1:0] src_sel(hz_slot_t ex, hz_slot_t mem, logic [REG_W-1:0] r);
    return writes(ex, r) ? (ex.memread ? FWD_RF : FWD_MEM) : writes(mem, r) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hz_slot_reg.sv
// hz_slot_reg: one pipeline tracker slot with synchronous active-low clear.
module hz_slot_reg
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SLOT_W-1:0] d_i,
  output logic [SLOT_W-1:0] q_o
);
  logic [SLOT_W-1:0] slot_q;
  always_ff @(posedge clk) slot_q <= reset ? d_i : '0;
  assign q_o = slot_q;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: stall/bubble detection, registered EX forwarding selects and ID CBZ forwarding.
// Optional HAZARD_PERF_EN adds a saturating stall_count output.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             id_is_cbz,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`ifdef HAZARD_PERF_EN
  output logic [15:0]      stall_count,
`endif
  output logic [1:0]       cbz_fwd
);
  hz_slot_t ex_d, ex_q, mem_q, wb_q;
  logic load_use, cbz_haz, kill;
  logic [1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  hz_slot_reg u_ex  (.clk(clk), .reset(reset), .d_i(ex_d),  .q_o(ex_q));
  hz_slot_reg u_mem (.clk(clk), .reset(reset), .d_i(ex_q),  .q_o(mem_q));
  hz_slot_reg u_wb  (.clk(clk), .reset(reset), .d_i(mem_q), .q_o(wb_q));
  always_comb begin
    load_use = ex_q.memread && ((id_rn_used && writes(ex_q, id_rn)) || (id_rm_used && writes(ex_q, id_rm)));
    cbz_haz  = id_is_cbz && (writes(ex_q, id_rm) || (mem_q.memread && writes(mem_q, id_rm)));
    stall    = reset && id_valid && !flush && (load_use || cbz_haz);
    kill     = stall || flush || !id_valid;
    ex_d     = '{valid: !kill, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
    fwd_a_d  = (kill || !id_rn_used) ? FWD_RF : src_sel(ex_q, mem_q, id_rn);
    fwd_b_d  = (kill || !id_rm_used) ? FWD_RF : src_sel(ex_q, mem_q, id_rm);
    cbz_fwd  = (writes(mem_q, id_rm) && !mem_q.memread) ? FWD_MEM : writes(wb_q, id_rm) ? FWD_WB : FWD_RF;
  end
  always_ff @(posedge clk) begin
    fwd_a_q <= reset ? fwd_a_d : FWD_RF;
    fwd_b_q <= reset ? fwd_b_d : FWD_RF;
  end
  assign bubble = stall;
  assign fwd_a  = fwd_a_q;
  assign fwd_b  = fwd_b_q;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q;
  always_ff @(posedge clk)
    if (!reset) stall_count_q <= '0;
    else if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
  assign stall_count = stall_count_q;
`endif
endmodule
